// File: rtl/flash_byte_sequencer.sv
// Flash byte sequencer: fetches 32-bit words from a flash word range and
// streams them out one byte at a time, ascending or descending.
`timescale 1ns/1ps
module flash_byte_sequencer #(
  parameter int unsigned WORD_DELTA = 1,
  parameter int          LOOP       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        reverse,
  input  logic [22:0] start_word,
  input  logic [22:0] end_word,
  output logic        flash_read,
  output logic [22:0] flash_address,
  input  logic        flash_waitrequest,
  input  logic        flash_readdatavalid,
  input  logic [31:0] flash_readdata,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        busy,
  output logic        wrap
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    SERVE,
    DRAIN
  } state_t;

  localparam logic [22:0] DELTA = 23'(WORD_DELTA);

  state_t      state, state_nxt;
  logic [22:0] word, word_nxt;
  logic [1:0]  byte_sel, byte_sel_nxt;
  logic [31:0] buffer, buffer_nxt;
  logic        wrap_nxt;
  logic        accept;

  // A stop in REQ withdraws the request in the same cycle, so an aborted
  // request can never be accepted by the flash and leave a read behind.
  assign flash_read    = (state == REQ) && !stop;
  assign flash_address = word;
  assign byte_valid    = (state == SERVE);
  assign byte_data     = buffer[{byte_sel, 3'b000} +: 8];
  assign busy          = (state != IDLE);
  assign accept        = byte_valid && byte_ready;

  // State, position, data buffer and wrap pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word     <= '0;
      byte_sel <= '0;
      buffer   <= '0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      word     <= word_nxt;
      byte_sel <= byte_sel_nxt;
      buffer   <= buffer_nxt;
      wrap     <= wrap_nxt;
    end
  end

  // Next-state logic: fetch, serve bytes, step the position and handle limits.
  always_comb begin
    state_nxt    = state;
    word_nxt     = word;
    byte_sel_nxt = byte_sel;
    buffer_nxt   = buffer;
    wrap_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!stop && start) begin
          state_nxt = REQ;
          if (reverse) begin
            word_nxt     = end_word;
            byte_sel_nxt = 2'd3;
          end else begin
            word_nxt     = start_word;
            byte_sel_nxt = 2'd0;
          end
        end
      end
      REQ: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (!flash_waitrequest) begin
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash_readdatavalid) begin
          if (stop) begin
            state_nxt = IDLE;
          end else begin
            buffer_nxt = flash_readdata;
            state_nxt  = SERVE;
          end
        end else if (stop) begin
          state_nxt = DRAIN;
        end
      end
      SERVE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (accept) begin
          if (!reverse) begin
            if (byte_sel != 2'd3) begin
              byte_sel_nxt = byte_sel + 2'd1;
            end else if (word >= end_word) begin
              wrap_nxt = 1'b1;
              if (LOOP != 0) begin
                word_nxt     = start_word;
                byte_sel_nxt = 2'd0;
                state_nxt    = REQ;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              word_nxt     = word + DELTA;
              byte_sel_nxt = 2'd0;
              state_nxt    = REQ;
            end
          end else begin
            if (byte_sel != 2'd0) begin
              byte_sel_nxt = byte_sel - 2'd1;
            end else if (word <= start_word) begin
              wrap_nxt = 1'b1;
              if (LOOP != 0) begin
                word_nxt     = end_word;
                byte_sel_nxt = 2'd3;
                state_nxt    = REQ;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              word_nxt     = word - DELTA;
              byte_sel_nxt = 2'd3;
              state_nxt    = REQ;
            end
          end
        end
      end
      DRAIN: begin
        if (flash_readdatavalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
